// File: rtl/sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_ctrl_pkg
// Description : Shared types and cycle-count helpers for the 32Kx8 SRAM front end.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_ctrl_pkg;

    localparam int TMR_W = 8;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_WAIT  = 3'd1,
        S_WR_SETUP = 3'd2,
        S_WR_PULSE = 3'd3,
        S_WR_REC   = 3'd4
    } state_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // A chip timing of any length still costs at least one clock
    function automatic int cyc(input int t_ns, input int clk_ns);
        return imax(ceil_div(t_ns, clk_ns), 1);
    endfunction

    function automatic int rd_cyc(input int clk_ns, input int taa, input int trc);
        return imax(cyc(taa, clk_ns), cyc(trc, clk_ns));
    endfunction

    function automatic int hz_cyc(input int clk_ns, input int twhz);
        return cyc(twhz, clk_ns);
    endfunction

    function automatic int wp_cyc(input int clk_ns, input int twp, input int taw,
                                  input int twhz, input int tdw);
        return imax(imax(cyc(twp, clk_ns), cyc(taw, clk_ns)),
                    cyc(twhz, clk_ns) + cyc(tdw, clk_ns));
    endfunction

    function automatic int rec_cyc(input int clk_ns, input int twc, input int wp);
        return imax(0, cyc(twc, clk_ns) - 1 - wp);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_ctrl_timer.sv
`default_nettype none
// ============================================================================
// Module      : sram_ctrl_timer
// Description : Loadable down-counter; expiry flags the last cycle of a phase.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_ctrl_timer
    import sram_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [TMR_W-1:0] i_load_val,
    input  logic             i_en,
    output logic [TMR_W-1:0] o_count,
    output logic             o_expired
);

    localparam logic [TMR_W-1:0] c_ONE = TMR_W'(1);

    logic [TMR_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - c_ONE;
        end
    end

    assign o_count   = r_count;
    assign o_expired = (r_count == c_ONE);

endmodule
`default_nettype wire

// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_ctrl
// Description : Valid/ready request to asynchronous 32Kx8 SRAM cycle converter.
//               Optional write readback/compare: define SRAM_CTRL_READBACK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int CLK_NS = 10,
    parameter int TAA    = 55,
    parameter int TRC    = 55,
    parameter int TWC    = 55,
    parameter int TAW    = 50,
    parameter int TWP    = 45,
    parameter int TWHZ   = 20,
    parameter int TDW    = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [14:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
`ifdef SRAM_CTRL_READBACK_EN
    output logic        rsp_err,
`endif
    output logic [14:0] sram_addr,
    output logic        sram_write,
    inout  wire  [7:0]  sram_data
);

    localparam int c_RD_CYC  = rd_cyc(CLK_NS, TAA, TRC);
    localparam int c_HZ_CYC  = hz_cyc(CLK_NS, TWHZ);
    localparam int c_WP_CYC  = wp_cyc(CLK_NS, TWP, TAW, TWHZ, TDW);
    localparam int c_REC_CYC = rec_cyc(CLK_NS, TWC, c_WP_CYC);

    localparam logic [TMR_W-1:0] c_RD_LD  = TMR_W'(c_RD_CYC);
    localparam logic [TMR_W-1:0] c_WP_LD  = TMR_W'(c_WP_CYC);
    localparam logic [TMR_W-1:0] c_REC_LD = TMR_W'(c_REC_CYC);
    // Counter value at the edge that completes HZ_CYC cycles of strobe low
    localparam logic [TMR_W-1:0] c_DRV_AT = TMR_W'(c_WP_CYC - c_HZ_CYC + 1);

`ifdef SRAM_CTRL_READBACK_EN
    localparam state_t c_AFTER_WR = S_RD_WAIT;
    localparam logic   c_RB       = 1'b1;
`else
    localparam state_t c_AFTER_WR = S_IDLE;
    localparam logic   c_RB       = 1'b0;
`endif

    state_t           r_state;
    logic [7:0]       r_wdata;
    logic             r_drv_en;
`ifdef SRAM_CTRL_READBACK_EN
    logic             r_rb;
`endif

    logic             w_accept;
    logic             w_tmr_load;
    logic [TMR_W-1:0] w_tmr_val;
    logic             w_tmr_en;
    logic [TMR_W-1:0] w_tmr_count;
    logic             w_tmr_expired;

    assign w_accept  = req_valid && req_ready;
    assign w_tmr_en  = (r_state == S_RD_WAIT) || (r_state == S_WR_PULSE) ||
                       (r_state == S_WR_REC);
    assign sram_data = r_drv_en ? r_wdata : 8'bz;

    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = c_RD_LD;
        case (r_state)
            S_IDLE:     w_tmr_load = w_accept && !req_write;
            S_WR_SETUP: begin
                w_tmr_load = 1'b1;
                w_tmr_val  = c_WP_LD;
            end
            S_WR_PULSE: begin
                if (w_tmr_expired) begin
                    if (c_REC_CYC != 0) begin
                        w_tmr_load = 1'b1;
                        w_tmr_val  = c_REC_LD;
                    end else begin
                        w_tmr_load = c_RB;
                    end
                end
            end
            S_WR_REC:   w_tmr_load = w_tmr_expired && c_RB;
            default:    ;
        endcase
    end

    sram_ctrl_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_en       (w_tmr_en),
        .o_count    (w_tmr_count),
        .o_expired  (w_tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 8'h00;
            sram_addr  <= 15'h0000;
            sram_write <= 1'b1;
            r_drv_en   <= 1'b0;
            r_wdata    <= 8'h00;
`ifdef SRAM_CTRL_READBACK_EN
            rsp_err    <= 1'b0;
            r_rb       <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        req_ready <= 1'b0;
                        sram_addr <= req_addr;
                        r_wdata   <= req_wdata;
                        r_state   <= req_write ? S_WR_SETUP : S_RD_WAIT;
`ifdef SRAM_CTRL_READBACK_EN
                        r_rb      <= req_write;
`endif
                    end
                end
                S_RD_WAIT: begin
                    if (w_tmr_expired) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= sram_data;
                        req_ready <= 1'b1;
                        r_state   <= S_IDLE;
`ifdef SRAM_CTRL_READBACK_EN
                        // Written as if/else so an unknown compare reports an error
                        if (!r_rb || (sram_data == r_wdata)) begin
                            rsp_err <= 1'b0;
                        end else begin
                            rsp_err <= 1'b1;
                        end
`endif
                    end
                end
                S_WR_SETUP: begin
                    sram_write <= 1'b0;
                    r_state    <= S_WR_PULSE;
                end
                S_WR_PULSE: begin
                    if (w_tmr_expired) begin
                        sram_write <= 1'b1;
                        r_drv_en   <= 1'b0;
                        if (c_REC_CYC != 0) begin
                            r_state <= S_WR_REC;
                        end else begin
                            r_state   <= c_AFTER_WR;
                            req_ready <= !c_RB;
                        end
                    end else if (w_tmr_count == c_DRV_AT) begin
                        r_drv_en <= 1'b1;
                    end
                end
                S_WR_REC: begin
                    if (w_tmr_expired) begin
                        r_state   <= c_AFTER_WR;
                        req_ready <= !c_RB;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
